// File: rtl/mdu_unit.sv
// Iterative multiply/divide unit for the EX stage; owns HI/LO and runs
// MULT/MULTU over a fixed number of cycles and DIV/DIVU as restoring division.
module mdu_unit #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_ITERS  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        mdu_stall,
    output logic        mdu_done,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    localparam logic [5:0] MUL_LAST = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DIV_LAST = 6'(DIV_ITERS - 1);

    logic [2:0]  state;
    logic [5:0]  cnt;
    logic [31:0] hi_q, lo_q;
    logic [31:0] op_a, op_b;
    logic        mul_signed;
    logic [31:0] divisor, rem, quo;
    logic        quo_neg, rem_neg, div_zero;

    logic        is_muldiv;
    logic        div_signed, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [63:0] mul_a_ext, mul_b_ext, prod;
    logic [32:0] shifted;
    logic [31:0] trial;
    logic        borrow;

    assign is_muldiv = (op == OP_MULT) || (op == OP_MULTU) ||
                       (op == OP_DIV)  || (op == OP_DIVU);

    assign div_signed = (op == OP_DIV);
    assign a_neg      = div_signed & a[31];
    assign b_neg      = div_signed & b[31];
    assign a_mag      = a_neg ? -a : a;
    assign b_mag      = b_neg ? -b : b;

    // Sign- or zero-extending to 64 bits lets one unsigned multiply serve both ops.
    assign mul_a_ext = {{32{mul_signed & op_a[31]}}, op_a};
    assign mul_b_ext = {{32{mul_signed & op_b[31]}}, op_b};
    assign prod      = mul_a_ext * mul_b_ext;

    assign shifted = {rem, quo[31]};
    assign borrow  = shifted < {1'b0, divisor};
    assign trial   = shifted[31:0] - divisor;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= 6'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            op_a       <= 32'd0;
            op_b       <= 32'd0;
            mul_signed <= 1'b0;
            divisor    <= 32'd0;
            rem        <= 32'd0;
            quo        <= 32'd0;
            quo_neg    <= 1'b0;
            rem_neg    <= 1'b0;
            div_zero   <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
            cnt   <= 6'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                op_a       <= a;
                                op_b       <= b;
                                mul_signed <= (op == OP_MULT);
                                cnt        <= MUL_LAST;
                                state      <= S_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                op_a     <= a;
                                quo      <= a_mag;
                                rem      <= 32'd0;
                                divisor  <= b_mag;
                                quo_neg  <= a_neg ^ b_neg;
                                rem_neg  <= a_neg;
                                div_zero <= (b == 32'd0);
                                cnt      <= DIV_LAST;
                                state    <= S_DIV;
                            end
                            OP_MTHI: hi_q <= a;
                            OP_MTLO: lo_q <= a;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (cnt == 6'd0) begin
                        hi_q  <= prod[63:32];
                        lo_q  <= prod[31:0];
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt - 6'd1;
                    end
                end
                S_DIV: begin
                    rem <= borrow ? shifted[31:0] : trial;
                    quo <= {quo[30:0], ~borrow};
                    if (cnt == 6'd0) begin
                        state <= S_FIX;
                    end else begin
                        cnt <= cnt - 6'd1;
                    end
                end
                S_FIX: begin
                    // Divide by zero bypasses the sign fix-up and reports HI=a, LO=all ones.
                    if (div_zero) begin
                        hi_q <= op_a;
                        lo_q <= 32'hFFFF_FFFF;
                    end else begin
                        hi_q <= rem_neg ? -rem : rem;
                        lo_q <= quo_neg ? -quo : quo;
                    end
                    state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mdu_stall = ((state == S_IDLE) && start && is_muldiv) ||
                       (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
    assign mdu_done  = (state == S_DONE);
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: stimulus pushes expected HI/LO and done cycle,
// a monitor pops them on every done pulse.
module tb_mdu_unit;

    localparam int MUL_CYCLES = 4;
    localparam int DIV_LAT    = 34;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    logic        clk, rst, start, flush;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        mdu_stall, mdu_done;
    logic [31:0] hi_o, lo_o;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    mdu_unit #(.MUL_CYCLES(MUL_CYCLES), .DIV_ITERS(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .mdu_stall (mdu_stall),
        .mdu_done  (mdu_done),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference results from plain arithmetic on the architectural definitions.
    function automatic logic [63:0] refModel(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int          sx, sy, q, r;
        longint      sp;
        logic [63:0] up;
        sx = x;
        sy = y;
        case (o)
            OP_MULT: begin
                sp = longint'(sx) * longint'(sy);
                return sp;
            end
            OP_MULTU: begin
                up = {32'd0, x} * {32'd0, y};
                return up;
            end
            OP_DIV: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = sx / sy;
                r = sx % sy;
                return {r, q};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && mdu_done) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("done_cycle", 64'(cyc), 64'(e.cyc));
                    checkOutput("hi", {32'd0, hi_o}, {32'd0, e.hi});
                    checkOutput("lo", {32'd0, lo_o}, {32'd0, e.lo});
                end
            end
        end
    end

    // Issue one MUL/DIV op; start is held through the stall and, if hold_done, through DONE.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] eh, input logic [31:0] el, input bit hold_done);
        int   lat;
        exp_t e;
        lat = (o == OP_MULT || o == OP_MULTU) ? MUL_CYCLES + 1 : DIV_LAT;
        for (int k = 0; k < lat; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                start = 1'b1; op = o; a = x; b = y;
                e.hi = eh; e.lo = el; e.cyc = cyc + lat;
                sb.push_back(e);
                model_hi = eh; model_lo = el;
            end
            @(negedge clk);
            checkOutput("stall_busy", {63'd0, mdu_stall}, 64'd1);
        end
        @(posedge clk); #1;
        if (!hold_done) start = 1'b0;
        @(negedge clk);
        checkOutput("stall_done", {63'd0, mdu_stall}, 64'd0);
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            start = 1'b0; op = 3'b000; flush = 1'b0;
            @(negedge clk);
            checkOutput("stall_idle", {63'd0, mdu_stall}, 64'd0);
        end
    endtask

    task automatic mtOp(input logic [2:0] o, input logic [31:0] x, input logic fl);
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x; flush = fl;
        @(negedge clk);
        checkOutput("stall_mt", {63'd0, mdu_stall}, 64'd0);
        if (!fl) begin
            if (o == OP_MTHI) model_hi = x;
            else              model_lo = x;
        end
        @(posedge clk); #1;
        start = 1'b0; op = 3'b000; flush = 1'b0;
        @(negedge clk);
        checkOutput("mt_hi", {32'd0, hi_o}, {32'd0, model_hi});
        checkOutput("mt_lo", {32'd0, lo_o}, {32'd0, model_lo});
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        logic [63:0] rr;
        int          sel;

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'b000; a = 32'd0; b = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_hi", {32'd0, hi_o}, 64'd0);
        checkOutput("reset_lo", {32'd0, lo_o}, 64'd0);
        checkOutput("reset_stall", {63'd0, mdu_stall}, 64'd0);
        checkOutput("reset_done", {63'd0, mdu_done}, 64'd0);

        applyStimulus(OP_MULT,  32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        idleCycles(1);
        applyStimulus(OP_MULTU, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1, 1'b0);
        idleCycles(1);
        applyStimulus(OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        idleCycles(1);
        applyStimulus(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        idleCycles(1);
        applyStimulus(OP_DIVU, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0);
        idleCycles(1);
        applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        idleCycles(1);

        // Start held through DONE, then dropped: a single op.
        applyStimulus(OP_DIV, 32'd50, 32'd6, 32'd2, 32'd8, 1'b1);
        idleCycles(3);
        // Start held through DONE and the next cycle: a second op is accepted.
        applyStimulus(OP_DIVU, 32'd9, 32'd4, 32'd1, 32'd2, 1'b1);
        applyStimulus(OP_DIVU, 32'd9, 32'd4, 32'd1, 32'd2, 1'b0);
        idleCycles(2);

        // Flush during divide iteration 10 leaves HI/LO untouched.
        mtOp(OP_MTHI, 32'h1111_1111, 1'b0);
        mtOp(OP_MTLO, 32'h1111_1111, 1'b0);
        @(posedge clk); #1;
        start = 1'b1; op = OP_DIV; a = 32'd1000; b = 32'd3;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (k == 10) begin
                flush = 1'b1; start = 1'b0;
            end
        end
        @(negedge clk);
        checkOutput("stall_pre_flush", {63'd0, mdu_stall}, 64'd1);
        idleCycles(40);
        checkOutput("flush_hi", {32'd0, hi_o}, 64'h1111_1111);
        checkOutput("flush_lo", {32'd0, lo_o}, 64'h1111_1111);

        // Reset in the middle of a multiply.
        @(posedge clk); #1;
        start = 1'b1; op = OP_MULT; a = 32'd7; b = 32'd9;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_hi = 32'd0; model_lo = 32'd0;
        @(negedge clk);
        checkOutput("rst_mid_hi", {32'd0, hi_o}, 64'd0);
        checkOutput("rst_mid_lo", {32'd0, lo_o}, 64'd0);
        checkOutput("rst_mid_stall", {63'd0, mdu_stall}, 64'd0);
        idleCycles(8);

        mtOp(OP_MTHI, 32'hCAFE_BABE, 1'b0);
        mtOp(OP_MTLO, 32'hDEAD_BEEF, 1'b1);

        // start with op=none or 111: no stall, no done.
        @(posedge clk); #1;
        start = 1'b1; op = 3'b111; a = 32'd5;
        @(negedge clk);
        checkOutput("stall_op7", {63'd0, mdu_stall}, 64'd0);
        @(posedge clk); #1;
        op = 3'b000;
        @(negedge clk);
        checkOutput("stall_op0", {63'd0, mdu_stall}, 64'd0);
        idleCycles(3);

        for (int n = 0; n < 24; n++) begin
            ro  = 3'($urandom_range(1, 4));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) rb = 32'($urandom_range(1, 20));
            else if (sel == 3) rb = -32'($urandom_range(1, 20));
            rr = refModel(ro, ra, rb);
            applyStimulus(ro, ra, rb, rr[63:32], rr[31:0], 1'b0);
            idleCycles(1);
        end

        idleCycles(5);
        checkOutput("pending_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
Iterative multiply/divide unit in the EX stage of the 5-stage MIPS pipeline. It owns the HI/LO architectural registers and executes MULT/MULTU/DIV/DIVU/MTHI/MTLO. Its stall/done outputs drive the hazard controller's ALU_stall/ALU_done inputs. Its flush input comes from the exception-clean path.

Parameters:
MUL_CYCLES, 4, cycles spent in MUL state before result commit (legal range 1..31).
DIV_ITERS, 32, restoring-division iterations (fixed; must equal operand width).

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  level; instruction in EX requests an MDU op (held while pipeline is stalled)
op  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 none
a  in  32  rs operand (forwarded)
b  in  32  rt operand (forwarded)
flush  in  1  abort in-flight op (exception clean)
mdu_stall  out  1  to hazard ALU_stall
mdu_done  out  1  to hazard ALU_done; one-cycle pulse
hi_o  out  32  HI register (MFHI source)
lo_o  out  32  LO register (MFLO source)

Behaviour:
- Reset: state=IDLE; HI=LO=0; counter=0; mdu_stall=0; mdu_done=0. Reset mid-operation discards the op.
- States: IDLE, MUL, DIV, FIX, DONE. Counter is 6 bits.
- IDLE, start=1, op=MULT/MULTU:
  - Latch a, b, and signedness.
  - Go to MUL, counter=MUL_CYCLES-1.
  - mdu_stall is combinationally 1 in this accept cycle.
- IDLE, start=1, op=DIV/DIVU:
  - Latch |a| and |b| (signed) or a and b (unsigned), plus the quotient and remainder sign bits.
  - Go to DIV, counter=31. mdu_stall=1 in the accept cycle.
- IDLE, start=1, op=MTHI/MTLO: write a to HI/LO at the clock edge. No stall, no done; stay in IDLE.
- MUL:
  - Product is 64-bit signed/unsigned per op; implementation may pipeline it internally, commit timing is fixed.
  - Decrement counter; at counter=0, write HI=prod[63:32], LO=prod[31:0] and go to DONE.
- DIV:
  - One restoring step per cycle: shift remainder:quotient left by 1, trial-subtract divisor, set quotient bit if no borrow.
  - At counter=0 go to FIX.
- FIX:
  - Apply signs: quotient negated if sign(a)^sign(b); remainder takes sign(a).
  - Write LO=quotient, HI=remainder. Go to DONE.
- DONE: mdu_done=1, mdu_stall=0 for exactly one cycle. start is ignored in this cycle (the same instruction is still in EX). Next state is IDLE.
- mdu_stall = (IDLE & start & op in {MULT,MULTU,DIV,DIVU}) | MUL | DIV | FIX.
- Latency, accept cycle = cycle 0:
  - MUL: stall high for cycles 0..MUL_CYCLES; done in cycle MUL_CYCLES+1.
  - DIV: stall high for cycles 0..33; done in cycle 34.
- Divide by zero (DIV and DIVU): completes with normal latency; HI=a, LO=0xFFFFFFFF; no exception.
- Signed overflow (0x80000000 / -1): LO=0x80000000, HI=0.
- flush:
  - Any state → IDLE next cycle; HI/LO not written; mdu_stall deasserts next cycle; no done.
  - flush in IDLE blocks acceptance and MTHI/MTLO writes in that cycle.
  - flush in DONE is harmless, because HI/LO were already committed.
- rst has priority over flush; flush has priority over start.
- op=none or 111 with start=1: no action, no stall.
- hi_o/lo_o are direct register outputs; an MFHI/MFLO in EX during DONE sees the new values.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5, MUL_CYCLES=4 -> mdu_stall high 5 cycles, mdu_done pulse in cycle 5, HI=0xFFFFFFFF, LO=0xFFFFFFF1; MULTU same operands -> HI=0x00000004, LO=0xFFFFFFF1.
- DIV a=-7, b=2 -> stall cycles 0..33, done in cycle 34, LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU a=100, b=7 -> LO=14, HI=2.
- DIVU a=0x12345678, b=0 -> LO=0xFFFFFFFF, HI=0x12345678, normal latency; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- start held high through DONE and one more cycle with op=DIV -> exactly one operation, one done pulse; op re-accepted only if start is still high in the cycle after DONE.
- flush in DIV iteration 10 with HI=LO=0x11111111 beforehand -> IDLE next cycle, no done, HI/LO unchanged; rst mid-MUL -> HI=LO=0, stall=0.
- MTHI a=0xCAFEBABE in IDLE -> hi_o=0xCAFEBABE next cycle, mdu_stall stays 0; MTLO with flush=1 -> LO unchanged.
